// File: rtl/status_flag_unit.sv
// status_flag_unit: NZCV status register fed by EXE-stage ALU results and direct writes.
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   freeze_i        pipeline stall, holds all state
//   exe_valid_i     EXE instruction valid and passed its condition check
//   s_bit_i         EXE instruction requests a flag update
//   alu_cmd_i       EXE ALU command
//   alu_result_i    ALU result
//   alu_carry_i     ALU carry out
//   alu_overflow_i  ALU signed overflow
//   msr_we_i        direct flag write
//   msr_data_i      direct flag value {N,Z,C,V}
//   status_reg_o    registered flags {N,Z,C,V}
//   status_fwd_o    flags for the ID-stage condition check (bypassed when FWD_EN)
//   flags_written_o high for one cycle after any flag write
module status_flag_unit #(
    parameter bit       FWD_EN      = 1'b1,
    parameter bit [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        freeze_i,
    input  logic        exe_valid_i,
    input  logic        s_bit_i,
    input  logic [3:0]  alu_cmd_i,
    input  logic [31:0] alu_result_i,
    input  logic        alu_carry_i,
    input  logic        alu_overflow_i,
    input  logic        msr_we_i,
    input  logic [3:0]  msr_data_i,
    output logic [3:0]  status_reg_o,
    output logic [3:0]  status_fwd_o,
    output logic        flags_written_o
);
    logic [3:0] flags_q, flags_d, alu_flags;
    logic       written_q, written_d;
    logic       is_arith, is_logic, alu_upd;

    assign is_arith = alu_cmd_i inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
    assign is_logic = alu_cmd_i inside {4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000};
    assign alu_upd  = exe_valid_i & s_bit_i & (is_arith | is_logic);

    // Logical ops leave C and V untouched.
    assign alu_flags = {alu_result_i[31], alu_result_i == 32'd0,
                        is_arith ? alu_carry_i    : flags_q[1],
                        is_arith ? alu_overflow_i : flags_q[0]};

    always_comb begin
        flags_d   = freeze_i ? flags_q :
                    msr_we_i ? msr_data_i :
                    alu_upd  ? alu_flags : flags_q;
        written_d = freeze_i ? written_q : (msr_we_i | alu_upd);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q   <= RESET_FLAGS;
            written_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            written_q <= written_d;
        end
    end

    // flags_d already equals flags_q under freeze, so the bypass falls back to the register.
    assign status_reg_o    = flags_q;
    assign status_fwd_o    = FWD_EN ? flags_d : flags_q;
    assign flags_written_o = written_q;
endmodule

// File: tb/tb_status_flag_unit.sv
// tb_status_flag_unit: random and directed check of status_flag_unit against a flag model.
module tb_status_flag_unit;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        freeze = 1'b0, exe_valid = 1'b0, s_bit = 1'b0;
    logic [3:0]  alu_cmd = 4'd0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_carry = 1'b0, alu_overflow = 1'b0, msr_we = 1'b0;
    logic [3:0]  msr_data = 4'd0;
    logic [3:0]  reg1, fwd1, reg0, fwd0;
    logic        fw1, fw0;

    int         n_tests = 0, n_fail = 0;
    logic [3:0] m_flags = 4'b0000;
    logic       m_fw = 1'b0;
    logic [3:0] last_fwd1, last_fwd0;

    always #5 clk = ~clk;

    status_flag_unit #(.FWD_EN(1'b1), .RESET_FLAGS(4'b0000)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .freeze_i(freeze), .exe_valid_i(exe_valid),
        .s_bit_i(s_bit), .alu_cmd_i(alu_cmd), .alu_result_i(alu_result),
        .alu_carry_i(alu_carry), .alu_overflow_i(alu_overflow), .msr_we_i(msr_we),
        .msr_data_i(msr_data), .status_reg_o(reg1), .status_fwd_o(fwd1),
        .flags_written_o(fw1));

    status_flag_unit #(.FWD_EN(1'b0), .RESET_FLAGS(4'b0000)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .freeze_i(freeze), .exe_valid_i(exe_valid),
        .s_bit_i(s_bit), .alu_cmd_i(alu_cmd), .alu_result_i(alu_result),
        .alu_carry_i(alu_carry), .alu_overflow_i(alu_overflow), .msr_we_i(msr_we),
        .msr_data_i(msr_data), .status_reg_o(reg0), .status_fwd_o(fwd0),
        .flags_written_o(fw0));

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural rule: returns {flags_written, NZCV} after the edge.
    function automatic logic [4:0] ref_next(input logic fz, ev, sb, input logic [3:0] cmd,
                                            input logic [31:0] res, input logic c, v, mw,
                                            input logic [3:0] md);
        bit arith   = (cmd >= 4'd2 && cmd <= 4'd5);
        bit logical = (cmd == 4'd1 || (cmd >= 4'd6 && cmd <= 4'd9));
        if (fz) return {m_fw, m_flags};
        if (mw) return {1'b1, md};
        if (ev && sb && (arith || logical))
            return {1'b1, res[31], res == 32'd0, arith ? c : m_flags[1], arith ? v : m_flags[0]};
        return {1'b0, m_flags};
    endfunction

    task automatic step(input logic fz, ev, sb, input logic [3:0] cmd, input logic [31:0] res,
                        input logic c, v, mw, input logic [3:0] md);
        logic [4:0] nx;
        @(negedge clk);
        freeze = fz; exe_valid = ev; s_bit = sb; alu_cmd = cmd; alu_result = res;
        alu_carry = c; alu_overflow = v; msr_we = mw; msr_data = md;
        #1;
        nx = ref_next(fz, ev, sb, cmd, res, c, v, mw, md);
        last_fwd1 = fwd1;
        last_fwd0 = fwd0;
        chk("fwd_bypass", fwd1, nx[3:0]);
        chk("fwd_nobypass", fwd0, m_flags);
        @(posedge clk);
        #1;
        m_fw = nx[4];
        m_flags = nx[3:0];
        chk("reg_fwd1", reg1, m_flags);
        chk("reg_fwd0", reg0, m_flags);
        chk("written_fwd1", 4'(fw1), 4'(m_fw));
        chk("written_fwd0", 4'(fw0), 4'(m_fw));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Reset lands mid-cycle while a direct write is pending on the inputs.
    task automatic async_reset(input logic [3:0] md);
        @(negedge clk);
        freeze = 1'b0; exe_valid = 1'b0; s_bit = 1'b0; msr_we = 1'b1; msr_data = md;
        #2 rst_ni = 1'b0;
        #1;
        m_flags = 4'b0000;
        m_fw = 1'b0;
        chk("rst_reg1", reg1, 4'b0000);
        chk("rst_reg0", reg0, 4'b0000);
        chk("rst_written", 4'(fw1), 4'(1'b0));
        @(posedge clk);
        #1;
        chk("rst_hold_reg", reg1, 4'b0000);
        @(negedge clk);
        msr_we = 1'b0;
        rst_ni = 1'b1;
    endtask

    initial begin
        #1;
        chk("por_reg", reg1, 4'b0000);
        chk("por_written", 4'(fw1), 4'(1'b0));
        @(negedge clk);
        rst_ni = 1'b1;

        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'b1111);
        chk("msr_1111", reg1, 4'b1111);
        async_reset(4'b0101);
        chk("after_rst", reg1, 4'b0000);

        step(1'b0, 1'b1, 1'b1, 4'b0100, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("sub0_fwd_same_cycle", last_fwd1, 4'b0110);
        chk("sub0_reg", reg1, 4'b0110);
        chk("sub0_written", 4'(fw1), 4'(1'b1));
        idle();
        chk("written_one_pulse", 4'(fw1), 4'(1'b0));

        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 1'b1, 4'b0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("mov_keeps_cv", reg1, 4'b1011);

        idle();
        step(1'b0, 1'b1, 1'b0, 4'b0010, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("add_nos_reg", reg1, 4'b1011);
        chk("add_nos_fwd", last_fwd1, 4'b1011);
        chk("add_nos_written", 4'(fw1), 4'(1'b0));
        step(1'b0, 1'b0, 1'b1, 4'b0010, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("add_invalid_reg", reg1, 4'b1011);
        chk("add_invalid_written", 4'(fw1), 4'(1'b0));

        step(1'b1, 1'b1, 1'b1, 4'b0010, 32'd0, 1'b1, 1'b1, 1'b1, 4'b0110);
        chk("freeze_reg", reg1, 4'b1011);
        chk("freeze_fwd", last_fwd1, 4'b1011);
        step(1'b0, 1'b1, 1'b1, 4'b0010, 32'd0, 1'b1, 1'b1, 1'b1, 4'b1001);
        chk("msr_wins", reg1, 4'b1001);

        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 1'b1, 4'b0100, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("nofwd_old_value", last_fwd0, 4'b0000);
        chk("nofwd_reg", reg0, 4'b1000);
        chk("nofwd_fwd_next", fwd0, 4'b1000);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] res;
            int sel = $urandom_range(0, 3);
            res = (sel == 0) ? 32'd0 : (sel == 1) ? 32'h8000_0000 : $urandom;
            if ($urandom_range(0, 199) == 0) async_reset(4'($urandom_range(0, 15)));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), res, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
